// File: rtl/avmm_bridge_pkg.sv
// avmm_bridge_pkg
//   Types and defaults shared by the Avalon-MM credit bridge and its skid buffer.
//   - cmd_t        : command payload at the default bus widths {rd, wr, addr, wdata, be}
//   - skid_state_e : command buffer occupancy {EMPTY, ONE, FULL}
//   - cmd_width()  : packed payload width for arbitrary bus widths
package avmm_bridge_pkg;

    localparam int AVM_WIDTH_DEF        = 512;
    localparam int AVM_ADDR_WIDTH_DEF   = 64;
    localparam int AVM_BYTEEN_WIDTH_DEF = AVM_WIDTH_DEF / 8;

    typedef struct packed {
        logic                            rd;
        logic                            wr;
        logic [AVM_ADDR_WIDTH_DEF-1:0]   addr;
        logic [AVM_WIDTH_DEF-1:0]        wdata;
        logic [AVM_BYTEEN_WIDTH_DEF-1:0] be;
    } cmd_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Payload carried through the skid buffer: rd + wr + address + data + byteenable.
    function automatic int cmd_width(input int dw, input int aw, input int bw);
        return 2 + dw + aw + bw;
    endfunction

endpackage

// File: rtl/avmm_skid_buf.sv
// avmm_skid_buf
//   Two-entry skid buffer. O is the output register that drives the downstream
//   command; K catches one command accepted while O is stalled. Order is kept,
//   so a command reaches the output one clock after it is loaded.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   in_load        command accepted upstream this cycle (never asserted while full)
//   in_data[W]     command payload to capture
//   out_ready      downstream consumes O this cycle when out_valid
//   out_valid      O holds a command
//   full           both O and K hold commands (upstream must stall)
//   out_data[W]    payload in O
module avmm_skid_buf
    import avmm_bridge_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_load,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic         full,
    output logic [W-1:0] out_data
);

    skid_state_e  state, state_nx;
    logic [W-1:0] o_q, k_q;
    logic         load_o_in, load_o_k, load_k;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load_o_in = 1'b0;
        load_o_k  = 1'b0;
        load_k    = 1'b0;
        case (state)
            EMPTY: begin
                if (in_load) begin
                    load_o_in = 1'b1;
                    state_nx  = ONE;
                end
            end
            ONE: begin
                if (out_ready) begin
                    // O leaves this edge: refill it directly or drain to empty.
                    if (in_load) load_o_in = 1'b1;
                    else         state_nx  = EMPTY;
                end else if (in_load) begin
                    load_k   = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_o_k = 1'b1;
                    state_nx = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Payload registers clear on reset so the downstream bus idles at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q <= '0;
            k_q <= '0;
        end else begin
            if (load_o_in)     o_q <= in_data;
            else if (load_o_k) o_q <= k_q;
            if (load_k)        k_q <= in_data;
        end
    end

    assign out_valid = (state != EMPTY);
    assign full      = (state == FULL);
    assign out_data  = o_q;

endmodule

// File: rtl/avmm_credit_bridge.sv
// avmm_credit_bridge
//   Registered Avalon-MM pipeline stage between the write combiner (s0) and the
//   memory interface (m0). Commands pass through a two-entry skid buffer, read
//   responses through one register stage, and the number of reads accepted but
//   not yet returned on s0 is capped at MAX_PENDING_READS.
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   s0_waitrequest                upstream stall (driven only from flops)
//   s0_readdata/s0_readdatavalid  read response, m0 response delayed one clock
//   s0_writedata/address/byteenable/write/read   upstream command
//   m0_waitrequest                downstream stall
//   m0_readdata/m0_readdatavalid  read response from memory
//   m0_writedata/address/byteenable/write/read   registered downstream command
//   perf_rd_cnt/perf_wr_cnt/perf_stall_cnt  (only with AVMM_BRIDGE_PERF_CNT_EN)
//       wrapping counts of m0 read issues, m0 write issues, stalled s0 request cycles
// Build option
//   AVMM_BRIDGE_PERF_CNT_EN  adds the performance counters; datapath is unchanged.
module avmm_credit_bridge
    import avmm_bridge_pkg::*;
#(
    parameter int AVM_WIDTH         = AVM_WIDTH_DEF,
    parameter int AVM_ADDR_WIDTH    = AVM_ADDR_WIDTH_DEF,
    parameter int AVM_BYTEEN_WIDTH  = AVM_WIDTH / 8,
    parameter int MAX_PENDING_READS = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        s0_waitrequest,
    output logic [AVM_WIDTH-1:0]        s0_readdata,
    output logic                        s0_readdatavalid,
    input  logic [AVM_WIDTH-1:0]        s0_writedata,
    input  logic [AVM_ADDR_WIDTH-1:0]   s0_address,
    input  logic                        s0_write,
    input  logic                        s0_read,
    input  logic [AVM_BYTEEN_WIDTH-1:0] s0_byteenable,
    input  logic                        m0_waitrequest,
    input  logic [AVM_WIDTH-1:0]        m0_readdata,
    input  logic                        m0_readdatavalid,
    output logic [AVM_WIDTH-1:0]        m0_writedata,
    output logic [AVM_ADDR_WIDTH-1:0]   m0_address,
    output logic [AVM_BYTEEN_WIDTH-1:0] m0_byteenable,
    output logic                        m0_write,
    output logic                        m0_read
`ifdef AVMM_BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_rd_cnt,
    output logic [31:0]                 perf_wr_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int CMD_W = cmd_width(AVM_WIDTH, AVM_ADDR_WIDTH, AVM_BYTEEN_WIDTH);
    localparam int PW    = $clog2(MAX_PENDING_READS + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING_READS);

    logic             ready_q;
    logic             skid_full, o_valid, o_rd, o_wr;
    logic             accept, rd_inc, rd_dec;
    logic [PW-1:0]    pending;
    logic [CMD_W-1:0] cmd_in, cmd_out;

    // Holds s0 stalled through the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    // Every term is a flop, so there is no input-to-waitrequest path.
    // Credit exhaustion stalls writes too; commands share one in-order queue.
    assign s0_waitrequest = !ready_q | skid_full | (pending == PEND_MAX);
    assign accept         = (s0_read | s0_write) & !s0_waitrequest;

    assign cmd_in = {s0_read, s0_write, s0_address, s0_writedata, s0_byteenable};

    avmm_skid_buf #(.W(CMD_W)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_load   (accept),
        .in_data   (cmd_in),
        .out_ready (!m0_waitrequest),
        .out_valid (o_valid),
        .full      (skid_full),
        .out_data  (cmd_out)
    );

    assign {o_rd, o_wr, m0_address, m0_writedata, m0_byteenable} = cmd_out;
    // O keeps its last payload after draining, so qualify the strobes with occupancy.
    assign m0_read  = o_valid & o_rd;
    assign m0_write = o_valid & o_wr;

    // Credits are returned by the registered s0 response, not the raw m0 one.
    assign rd_inc = accept & s0_read;
    assign rd_dec = s0_readdatavalid & (pending != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            case ({rd_inc, rd_dec})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_readdatavalid <= 1'b0;
            s0_readdata      <= '0;
        end else begin
            s0_readdatavalid <= m0_readdatavalid;
            if (m0_readdatavalid) s0_readdata <= m0_readdata;
        end
    end

`ifdef AVMM_BRIDGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (m0_read & !m0_waitrequest)             perf_rd_cnt    <= perf_rd_cnt + 32'd1;
            if (m0_write & !m0_waitrequest)            perf_wr_cnt    <= perf_wr_cnt + 32'd1;
            if ((s0_read | s0_write) & s0_waitrequest) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avmm_credit_bridge.sv
// tb_avmm_credit_bridge
//   Bench for avmm_credit_bridge with MAX_PENDING_READS=4. A negedge monitor keeps
//   command and response scoreboards; the main thread walks a vector table and
//   hand-written sequences for credit limit, response timing and mid-run reset.
//   Define AVMM_BRIDGE_PERF_CNT_EN to also check the performance counters.
module tb_avmm_credit_bridge;
    import avmm_bridge_pkg::*;

    localparam int DW = 512, AW = 64, BW = 64, MAXP = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s0_waitrequest, s0_readdatavalid, s0_write, s0_read;
    logic [DW-1:0] s0_readdata, s0_writedata, m0_readdata, m0_writedata;
    logic [AW-1:0] s0_address, m0_address;
    logic [BW-1:0] s0_byteenable, m0_byteenable;
    logic          m0_waitrequest, m0_readdatavalid, m0_write, m0_read;
`ifdef AVMM_BRIDGE_PERF_CNT_EN
    logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    avmm_credit_bridge #(
        .AVM_WIDTH(DW), .AVM_ADDR_WIDTH(AW), .AVM_BYTEEN_WIDTH(BW), .MAX_PENDING_READS(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s0_writedata(s0_writedata), .s0_address(s0_address), .s0_write(s0_write), .s0_read(s0_read),
        .s0_byteenable(s0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m0_writedata(m0_writedata), .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_write(m0_write), .m0_read(m0_read)
`ifdef AVMM_BRIDGE_PERF_CNT_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int n_checks = 0, n_fail = 0, cyc = 0, stall_seen = 0;

    typedef struct { logic [DW-1:0] data; int stamp; } rsp_t;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mon_c;
    rsp_t mon_r;

    typedef struct {
        logic          wr;
        logic [63:0]   addr;
        logic          mw;
        logic          e_wait;
        logic          e_mwr;
        logic [63:0]   e_addr;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [63:0] a);
        return {8{a ^ 64'hA5A5_0000_0000_0000}};
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [63:0] a);
        s0_read       = rd;
        s0_write      = wr;
        s0_address    = a;
        s0_writedata  = pat(a);
        s0_byteenable = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: m0 transfers must match accepted s0 commands in order;
    // each m0 response must reappear on s0 exactly one cycle later.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            cmd_q.delete();
            rsp_q.delete();
        end else begin
            if ((m0_read | m0_write) && !m0_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL cmd_spurious: got m0 addr %0h expected no command", m0_address);
                end else begin
                    mon_c = cmd_q.pop_front();
                    check("cmd_rd", 64'(m0_read), 64'(mon_c.rd));
                    check("cmd_wr", 64'(m0_write), 64'(mon_c.wr));
                    check("cmd_addr", m0_address, mon_c.addr);
                    check("cmd_be", m0_byteenable, mon_c.be);
                    check_data("cmd_wdata", m0_writedata, mon_c.wdata);
                end
            end
            if ((s0_read | s0_write) && !s0_waitrequest) begin
                mon_c.rd = s0_read; mon_c.wr = s0_write; mon_c.addr = s0_address;
                mon_c.wdata = s0_writedata; mon_c.be = s0_byteenable;
                cmd_q.push_back(mon_c);
            end
            if (s0_readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_spurious: got s0_readdatavalid=1 expected 0");
                end else begin
                    mon_r = rsp_q.pop_front();
                    check_data("rsp_data", s0_readdata, mon_r.data);
                    check("rsp_latency", 64'(cyc - mon_r.stamp), 64'd1);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].stamp < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL rsp_missing: got s0_readdatavalid=0 expected 1");
                void'(rsp_q.pop_front());
            end
            if (m0_readdatavalid) begin
                mon_r.data = m0_readdata; mon_r.stamp = cyc;
                rsp_q.push_back(mon_r);
            end
            if ((s0_read | s0_write) && s0_waitrequest) stall_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st0;
        logic [DW-1:0] d1, d2, d3;
`ifdef AVMM_BRIDGE_PERF_CNT_EN
        logic [31:0] wr0, pst0;
`endif
        // Scenarios 1 and 2: single write, then three writes against a stalled m0.
        vecs[0] = '{1'b1, 64'h40,  1'b0, 1'b0, 1'b1, 64'h40};
        vecs[1] = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 64'h100, 1'b1, 1'b0, 1'b1, 64'h100};
        vecs[3] = '{1'b1, 64'h140, 1'b1, 1'b1, 1'b1, 64'h100};
        vecs[4] = '{1'b1, 64'h180, 1'b1, 1'b1, 1'b1, 64'h100};
        vecs[5] = '{1'b1, 64'h180, 1'b0, 1'b0, 1'b1, 64'h140};
        vecs[6] = '{1'b1, 64'h180, 1'b0, 1'b0, 1'b1, 64'h180};
        vecs[7] = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h0};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0);
        m0_waitrequest = 1'b0; m0_readdatavalid = 1'b0; m0_readdata = '0;
        tick();
        check("rst_wait", 64'(s0_waitrequest), 64'd1);
        check("rst_m0_read", 64'(m0_read), 64'd0);
        check("rst_m0_write", 64'(m0_write), 64'd0);
        check("rst_m0_addr", m0_address, 64'd0);
        check("rst_rdv", 64'(s0_readdatavalid), 64'd0);
        check_data("rst_rdata", s0_readdata, '0);
        @(posedge clk); #3 reset_n = 1'b1;
        #1 check("wait_at_release", 64'(s0_waitrequest), 64'd1);
        tick();
        check("wait_first_edge", 64'(s0_waitrequest), 64'd0);

        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                st0 = stall_seen;
`ifdef AVMM_BRIDGE_PERF_CNT_EN
                wr0 = perf_wr_cnt; pst0 = perf_stall_cnt;
`endif
            end
            drive(1'b0, vecs[i].wr, vecs[i].addr);
            m0_waitrequest = vecs[i].mw;
            tick();
            check($sformatf("vec%0d_wait", i), 64'(s0_waitrequest), 64'(vecs[i].e_wait));
            check($sformatf("vec%0d_m0_write", i), 64'(m0_write), 64'(vecs[i].e_mwr));
            if (vecs[i].e_mwr) check($sformatf("vec%0d_m0_addr", i), m0_address, vecs[i].e_addr);
        end
        check("s2_stall_cycles", 64'(stall_seen - st0), 64'd2);
`ifdef AVMM_BRIDGE_PERF_CNT_EN
        check("perf_wr_cnt", 64'(perf_wr_cnt - wr0), 64'd3);
        check("perf_stall_cnt", 64'(perf_stall_cnt - pst0), 64'(stall_seen - st0));
`endif

        // Scenario 3: credit limit of 4 reads, memory silent.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 64'h1000 + 64'(i * 64));
            tick();
            check($sformatf("s3_rd%0d_wait", i), 64'(s0_waitrequest), 64'(i == 3));
        end
        drive(1'b1, 1'b0, 64'h1100);
        tick(); check("s3_hold1_wait", 64'(s0_waitrequest), 64'd1);
        tick(); check("s3_hold2_wait", 64'(s0_waitrequest), 64'd1);
        check("s3_hold2_m0_read", 64'(m0_read), 64'd0);
        m0_readdatavalid = 1'b1; m0_readdata = {16{$urandom}};
        tick(); m0_readdatavalid = 1'b0;
        check("s3_rsp_wait", 64'(s0_waitrequest), 64'd1);
        check("s3_rsp_rdv", 64'(s0_readdatavalid), 64'd1);
        tick(); check("s3_credit_wait", 64'(s0_waitrequest), 64'd0);
        tick(); check("s3_5th_m0_read", 64'(m0_read), 64'd1);
        check("s3_5th_addr", m0_address, 64'h1100);
        drive(1'b0, 1'b0, 64'h0);

        // Scenario 4: response timing/hold, then accept and return in the same cycle.
        d1 = {32{16'hDEAD}}; d2 = {16{$urandom}}; d3 = {16{$urandom}};
        m0_readdatavalid = 1'b1; m0_readdata = d1;
        tick(); check("s4_rdv", 64'(s0_readdatavalid), 64'd1);
        check_data("s4_rdata", s0_readdata, d1);
        m0_readdata = d2; tick();
        m0_readdata = d3; tick();
        m0_readdatavalid = 1'b0; m0_readdata = '0;
        drive(1'b1, 1'b0, 64'h2000);
        tick();
        check("s4_rdv_low", 64'(s0_readdatavalid), 64'd0);
        check_data("s4_rdata_hold", s0_readdata, d3);
        check("s4_same_cycle_wait", 64'(s0_waitrequest), 64'd0);
        drive(1'b1, 1'b0, 64'h2040); tick();
        check("s4_rd_e_wait", 64'(s0_waitrequest), 64'd0);
        drive(1'b1, 1'b0, 64'h2080); tick();
        check("s4_rd_f_wait", 64'(s0_waitrequest), 64'd1);
        drive(1'b1, 1'b0, 64'h20C0); tick();
        check("s4_rd_g_wait", 64'(s0_waitrequest), 64'd1);
        drive(1'b0, 1'b0, 64'h0);

        // Scenario 5: reset while FULL with 2 reads pending.
        m0_readdatavalid = 1'b1; m0_readdata = {16{$urandom}}; tick();
        m0_readdata = {16{$urandom}}; tick();
        m0_readdatavalid = 1'b0; tick();
        check("s5_two_pending_wait", 64'(s0_waitrequest), 64'd0);
        m0_waitrequest = 1'b1;
        drive(1'b0, 1'b1, 64'h3000); tick();
        drive(1'b0, 1'b1, 64'h3040); tick();
        drive(1'b0, 1'b0, 64'h0);
        check("s5_full_wait", 64'(s0_waitrequest), 64'd1);
        check("s5_full_m0_write", 64'(m0_write), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("s5_rst_m0_write", 64'(m0_write), 64'd0);
        check("s5_rst_m0_read", 64'(m0_read), 64'd0);
        check("s5_rst_wait", 64'(s0_waitrequest), 64'd1);
        m0_waitrequest = 1'b0;
        @(posedge clk); #3 reset_n = 1'b1;
        #1 check("s5_release_wait", 64'(s0_waitrequest), 64'd1);
        tick(); check("s5_ready_wait", 64'(s0_waitrequest), 64'd0);
        drive(1'b0, 1'b1, 64'h4000); tick();
        check("s5_new_write", 64'(m0_write), 64'd1);
        check("s5_new_addr", m0_address, 64'h4000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 64'h5000 + 64'(i * 64));
            tick();
            check($sformatf("s5_rd%0d_wait", i), 64'(s0_waitrequest), 64'(i == 3));
        end
        drive(1'b0, 1'b0, 64'h0);
        repeat (3) tick();
        check("sb_cmd_drained", 64'(cmd_q.size()), 64'd0);
        check("sb_rsp_drained", 64'(rsp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
